// File: rtl/rv32v_types_pkg.sv
// rv32v_types_pkg: shared rv32v element/load encodings plus vector memory serializer types
package rv32v_types_pkg;
  typedef enum logic [1:0] {SEW8 = 2'd0, SEW16 = 2'd1, SEW32 = 2'd2} sew_t;
  typedef enum logic [2:0] {LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5} load_t;
  typedef enum logic [1:0] {STRIDED = 2'd0, INDEXED = 2'd1, SEGMENT = 2'd2} serial_mode_t;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} serial_state_t;
  function automatic logic [2:0] eew_bytes(input sew_t e);
    return e == SEW32 ? 3'd4 : e == SEW16 ? 3'd2 : 3'd1;
  endfunction
endpackage

// File: rtl/rv32v_next_lane_finder.sv
// rv32v_next_lane_finder: lowest set mask bit at or above start, with found flag
//   mask  : lane mask to search
//   start : first index considered (one bit wider so lane+1 never wraps)
//   lane  : index of the lowest qualifying set bit (0 when none)
//   found : a qualifying bit exists
module rv32v_next_lane_finder #(
  parameter int NUM_LANES = 4,
  localparam int LANE_W = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] mask,
  input  logic [LANE_W:0]      start,
  output logic [LANE_W-1:0]    lane,
  output logic                 found
);
  always_comb begin
    lane = '0;
    found = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (mask[i] && (LANE_W+1)'(i) >= start) begin
        lane = LANE_W'(i);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/rv32v_mem_serializer_p.sv
// rv32v_mem_serializer_p: serializes one vector memory micro-op into scalar LSC accesses
//   CLK/RST            : clock, synchronous active-high reset
//   req_*              : micro-op request (valid/ready), latched on accept
//   fld_wdata          : segment store data for (mem_lane, mem_field)
//   mem_*              : scalar access to the load/store controller, held until mem_ready
//   serializer_stall   : busy and not finishing this cycle
//   done               : pulse on the final access handshake (or empty completion)
//   RV32V_SERIAL_LANE_SKIP_EN : when defined, masked lanes are skipped in zero cycles
module rv32v_mem_serializer_p
  import rv32v_types_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_NF = 8,
  localparam int LANE_W = $clog2(NUM_LANES),
  localparam int FLD_W = $clog2(MAX_NF)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_wen,
  input  logic [1:0]                  req_mode,
  input  logic                        req_first,
  input  logic [ADDR_W-1:0]           req_base,
  input  logic [ADDR_W-1:0]           req_stride,
  input  logic [1:0]                  req_eew,
  input  logic [FLD_W-1:0]            req_nf,
  input  logic [NUM_LANES-1:0]        req_mask,
  input  logic [NUM_LANES*ADDR_W-1:0] req_lane_addr,
  input  logic [NUM_LANES*DATA_W-1:0] req_store_data,
  input  logic [DATA_W-1:0]           fld_wdata,
  output logic                        mem_ren,
  output logic                        mem_wen,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output load_t                       mem_load_type,
  output logic [LANE_W-1:0]           mem_lane,
  output logic [FLD_W-1:0]            mem_field,
  input  logic                        mem_ready,
  output logic                        serializer_stall,
  output logic                        done
);
  serial_state_t state, state_n;
  serial_mode_t mode_r;
  sew_t eew_r;
  logic wen_r;
  logic [ADDR_W-1:0] cursor, cur_r, stride_r;
  logic [FLD_W-1:0] nf_r, field;
  logic [NUM_LANES-1:0] mask_r;
  logic [NUM_LANES*ADDR_W-1:0] laddr_r;
  logic [NUM_LANES*DATA_W-1:0] sdata_r;
  logic [LANE_W-1:0] lane, nxt_lane;
  logic accept, active, busy, fld_more, last;
`ifdef RV32V_SERIAL_LANE_SKIP_EN
  logic nxt_found;
  // In IDLE the finder looks at the incoming mask from lane 0 to pick the starting lane.
  rv32v_next_lane_finder #(.NUM_LANES(NUM_LANES)) u_finder (
    .mask(state == IDLE ? req_mask : mask_r),
    .start(state == IDLE ? '0 : (LANE_W+1)'(lane) + (LANE_W+1)'(1)),
    .lane(nxt_lane),
    .found(nxt_found)
  );
  assign last = !nxt_found;
`else
  assign nxt_lane = state == IDLE ? '0 : lane + LANE_W'(1);
  assign last = lane == LANE_W'(NUM_LANES - 1);
`endif
  always_comb begin
    req_ready = state == IDLE;
    accept = req_valid && req_ready;
    active = state == ACCESS && mask_r[lane];
    busy = active && !mem_ready;
    fld_more = active && mode_r == SEGMENT && field != nf_r;
    done = state == ACCESS && !busy && !fld_more && last;
    serializer_stall = state != IDLE && !done;
    mem_ren = active && !wen_r;
    mem_wen = active && wen_r;
    mem_lane = lane;
    mem_field = field;
    mem_addr = mode_r == INDEXED ? laddr_r[int'(lane)*ADDR_W +: ADDR_W]
             : cur_r + ADDR_W'(lane) * stride_r + ADDR_W'(field) * ADDR_W'(eew_bytes(eew_r));
    mem_wdata = mode_r == SEGMENT ? fld_wdata : sdata_r[int'(lane)*DATA_W +: DATA_W];
    mem_load_type = eew_r == SEW32 ? LW : eew_r == SEW16 ? LH : LB;
    state_n = accept ? ACCESS : done ? IDLE : state;
  end
  always_ff @(posedge CLK)
    if (RST) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge CLK)
    if (RST) begin
      cursor <= '0;
      cur_r <= '0;
      stride_r <= '0;
      wen_r <= 1'b0;
      mode_r <= STRIDED;
      eew_r <= SEW8;
      nf_r <= '0;
      mask_r <= '0;
      laddr_r <= '0;
      sdata_r <= '0;
      lane <= '0;
      field <= '0;
    end else if (accept) begin
      cur_r <= req_first ? req_base : cursor;
      stride_r <= req_stride;
      wen_r <= req_wen;
      mode_r <= req_mode == 2'd3 ? STRIDED : serial_mode_t'(req_mode);
      eew_r <= sew_t'(req_eew);
      nf_r <= req_nf;
      mask_r <= req_mask;
      laddr_r <= req_lane_addr;
      sdata_r <= req_store_data;
      lane <= nxt_lane;
      field <= '0;
    end else if (state == ACCESS && !busy) begin
      field <= fld_more ? field + FLD_W'(1) : '0;
      if (!fld_more) lane <= done ? '0 : nxt_lane;
      if (done && mode_r != INDEXED) cursor <= cur_r + ADDR_W'(NUM_LANES) * stride_r;
    end
endmodule

// File: tb/tb_rv32v_mem_serializer_p.sv
// tb_rv32v_mem_serializer_p: directed table-driven bench for rv32v_mem_serializer_p
module tb_rv32v_mem_serializer_p;
  import rv32v_types_pkg::*;
  logic CLK = 1'b0, RST = 1'b1;
  logic req_valid = 1'b0, req_wen = 1'b0, req_first = 1'b0, mem_ready = 1'b0;
  logic [1:0] req_mode = '0, req_eew = '0;
  logic [31:0] req_base = '0, req_stride = '0;
  logic [2:0] req_nf = '0;
  logic [3:0] req_mask = '0;
  logic [127:0] req_lane_addr = '0, req_store_data = '0;
  logic [31:0] fld_wdata, mem_addr, mem_wdata;
  logic req_ready, mem_ren, mem_wen, serializer_stall, done;
  load_t mem_load_type;
  logic [1:0] mem_lane;
  logic [2:0] mem_field;
  int checks = 0, errors = 0;
  always #5 CLK = ~CLK;
  assign fld_wdata = 32'hF000_0000 | {27'd0, mem_lane, mem_field};
  rv32v_mem_serializer_p dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_mode(req_mode), .req_first(req_first), .req_base(req_base), .req_stride(req_stride),
    .req_eew(req_eew), .req_nf(req_nf), .req_mask(req_mask), .req_lane_addr(req_lane_addr),
    .req_store_data(req_store_data), .fld_wdata(fld_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_load_type(mem_load_type), .mem_lane(mem_lane),
    .mem_field(mem_field), .mem_ready(mem_ready), .serializer_stall(serializer_stall), .done(done)
  );
  typedef struct packed {
    logic wen;
    logic [1:0] mode;
    logic first;
    logic [31:0] base;
    logic [31:0] stride;
    logic [1:0] eew;
    logic [2:0] nf;
    logic [3:0] mask;
    logic [3:0] waits;
    logic [127:0] laddr;
    logic [127:0] sdata;
    logic [3:0] n;
    logic [5:0][31:0] ea;
    logic [5:0][1:0] el;
    logic [5:0][2:0] ef;
    logic [7:0] cyc_on;
    logic [7:0] cyc_off;
    logic [2:0] lt;
  } vec_t;
  function automatic logic [5:0][31:0] a6(input logic [31:0] a, b, c, d, e, f);
    return {f, e, d, c, b, a};
  endfunction
  function automatic logic [5:0][1:0] l6(input int a, b, c, d, e, f);
    return {2'(f), 2'(e), 2'(d), 2'(c), 2'(b), 2'(a)};
  endfunction
  function automatic logic [5:0][2:0] f6(input int a, b, c, d, e, f);
    return {3'(f), 3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_op(input vec_t v, input string tag);
    int k = 0, wc = 0, cyc = 1, exp_cyc;
    logic req, prq = 1'b0, prd = 1'b0, got_done = 1'b0;
    logic [31:0] pa = '0, pd = '0, ed;
`ifdef RV32V_SERIAL_LANE_SKIP_EN
    exp_cyc = int'(v.cyc_on);
`else
    exp_cyc = int'(v.cyc_off);
`endif
    @(negedge CLK);
    chk({tag, " ready"}, 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_wen = v.wen;
    req_mode = v.mode;
    req_first = v.first;
    req_base = v.base;
    req_stride = v.stride;
    req_eew = v.eew;
    req_nf = v.nf;
    req_mask = v.mask;
    req_lane_addr = v.laddr;
    req_store_data = v.sdata;
    @(negedge CLK);
    req_valid = 1'b0;
    while (!got_done && cyc <= 64) begin
      #1;
      req = mem_ren | mem_wen;
      mem_ready = req ? (wc == int'(v.waits)) : 1'b1;
      #1;
      if (prq && !prd)
        chk($sformatf("%s hold c%0d", tag, cyc), {req, mem_addr, mem_wdata}, {1'b1, pa, pd});
      chk($sformatf("%s stall c%0d", tag, cyc), {serializer_stall, done}, {cyc != exp_cyc, cyc == exp_cyc});
      if (req && mem_ready) begin
        if (k < int'(v.n)) begin
          ed = v.mode == 2'd2 ? 32'hF000_0000 | {27'd0, v.el[k], v.ef[k]} : v.sdata[int'(v.el[k])*32 +: 32];
          chk($sformatf("%s access %0d", tag, k),
              {mem_lane, mem_field, mem_ren, mem_wen, mem_addr, v.wen ? mem_wdata : 32'd0, 3'(mem_load_type)},
              {v.el[k], v.ef[k], !v.wen, v.wen, v.ea[k], v.wen ? ed : 32'd0, v.lt});
        end
        k++;
      end
      wc = (req && !mem_ready) ? wc + 1 : 0;
      prq = req;
      prd = mem_ready;
      pa = mem_addr;
      pd = mem_wdata;
      got_done = done;
      if (!got_done) begin
        @(negedge CLK);
        cyc++;
      end
    end
    chk({tag, " cycles"}, 128'(cyc), 128'(exp_cyc));
    chk({tag, " count"}, 128'(k), 128'(v.n));
    @(negedge CLK);
    chk({tag, " idle"}, {req_ready, done, mem_ren, mem_wen}, 4'b1000);
  endtask
  vec_t tv [10];
  vec_t rv;
  initial begin
    tv[0] = '{first:1'b1, base:32'h1000, stride:32'd8, eew:2'd2, mask:4'hF, n:4'd4,
              ea:a6(32'h1000, 32'h1008, 32'h1010, 32'h1018, 0, 0), el:l6(0, 1, 2, 3, 0, 0),
              cyc_on:8'd4, cyc_off:8'd4, lt:3'd2, default:'0};
    tv[1] = '{stride:32'd8, eew:2'd2, mask:4'hF, n:4'd4,
              ea:a6(32'h1020, 32'h1028, 32'h1030, 32'h1038, 0, 0), el:l6(0, 1, 2, 3, 0, 0),
              cyc_on:8'd4, cyc_off:8'd4, lt:3'd2, default:'0};
    tv[2] = '{first:1'b1, base:32'h1000, stride:32'd8, eew:2'd2, mask:4'h9, n:4'd2,
              ea:a6(32'h1000, 32'h1018, 0, 0, 0, 0), el:l6(0, 3, 0, 0, 0, 0),
              cyc_on:8'd2, cyc_off:8'd4, lt:3'd2, default:'0};
    tv[3] = '{wen:1'b1, mode:2'd1, first:1'b1, base:32'h9999_0000, eew:2'd2, mask:4'hF, waits:4'd3,
              laddr:128'h00000100_000000C0_00000080_00000040,
              sdata:128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, n:4'd4,
              ea:a6(32'h40, 32'h80, 32'hC0, 32'h100, 0, 0), el:l6(0, 1, 2, 3, 0, 0),
              cyc_on:8'd16, cyc_off:8'd16, lt:3'd2, default:'0};
    tv[4] = '{stride:32'hFFFF_FFFC, eew:2'd2, mask:4'h6, n:4'd2,
              ea:a6(32'h101C, 32'h1018, 0, 0, 0, 0), el:l6(1, 2, 0, 0, 0, 0),
              cyc_on:8'd2, cyc_off:8'd4, lt:3'd2, default:'0};
    tv[5] = '{mode:2'd2, first:1'b1, base:32'h200, stride:32'd6, eew:2'd1, nf:3'd2, mask:4'h3, n:4'd6,
              ea:a6(32'h200, 32'h202, 32'h204, 32'h206, 32'h208, 32'h20A), el:l6(0, 0, 0, 1, 1, 1),
              ef:f6(0, 1, 2, 0, 1, 2), cyc_on:8'd6, cyc_off:8'd8, lt:3'd1, default:'0};
    tv[6] = '{wen:1'b1, mode:2'd2, first:1'b1, base:32'h400, stride:32'd8, eew:2'd2, nf:3'd1, mask:4'h4,
              waits:4'd1, n:4'd2, ea:a6(32'h410, 32'h414, 0, 0, 0, 0), el:l6(2, 2, 0, 0, 0, 0),
              ef:f6(0, 1, 0, 0, 0, 0), cyc_on:8'd4, cyc_off:8'd7, lt:3'd2, default:'0};
    tv[7] = '{stride:32'h10, eew:2'd2, cyc_on:8'd1, cyc_off:8'd4, lt:3'd2, default:'0};
    tv[8] = '{stride:32'd1, eew:2'd0, mask:4'hF, n:4'd4,
              ea:a6(32'h460, 32'h461, 32'h462, 32'h463, 0, 0), el:l6(0, 1, 2, 3, 0, 0),
              cyc_on:8'd4, cyc_off:8'd4, lt:3'd0, default:'0};
    tv[9] = '{mode:2'd3, first:1'b1, base:32'h3000, stride:32'h100, eew:2'd2, mask:4'h1, n:4'd1,
              ea:a6(32'h3000, 0, 0, 0, 0, 0), el:l6(0, 0, 0, 0, 0, 0),
              cyc_on:8'd1, cyc_off:8'd4, lt:3'd2, default:'0};
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("reset state", {req_ready, mem_ren, mem_wen, done, serializer_stall, mem_addr, mem_wdata,
        mem_lane, mem_field, 3'(mem_load_type)}, {1'b1, 4'b0, 32'd0, 32'd0, 2'd0, 3'd0, 3'd0});
    for (int i = 0; i < 10; i++) run_op(tv[i], $sformatf("vec%0d", i));
    @(negedge CLK);
    req_valid = 1'b1;
    req_wen = 1'b0;
    req_mode = 2'd0;
    req_first = 1'b1;
    req_base = 32'h5000;
    req_stride = 32'd4;
    req_eew = 2'd2;
    req_mask = 4'hF;
    mem_ready = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    chk("rst access0", {mem_ren, mem_addr}, {1'b1, 32'h5000});
    @(negedge CLK);
    chk("rst access1", {mem_ren, done, mem_addr}, {2'b10, 32'h5004});
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst no done", 128'(done), 128'(0));
    @(negedge CLK);
    RST = 1'b0;
    chk("rst after", {req_ready, mem_ren, mem_wen, done, serializer_stall, mem_addr, mem_lane, mem_field},
        {1'b1, 4'b0, 32'd0, 2'd0, 3'd0});
    rv = '{base:32'hBAD0, stride:32'd4, eew:2'd2, mask:4'h1, n:4'd1, ea:a6(0, 0, 0, 0, 0, 0),
           el:l6(0, 0, 0, 0, 0, 0), cyc_on:8'd1, cyc_off:8'd4, lt:3'd2, default:'0};
    run_op(rv, "post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
